// File: rtl/waveform_prefetch.sv
// Streaming sample fetcher: reads pairs of RAM words over the DMA port, packs them into
// DAC samples and buffers them in a small FIFO served over the word_next/word_ok handshake.
module waveform_prefetch #(
  parameter int WORD_WID       = 20,
  parameter int WORD_AMNT_WID  = 11,
  parameter int WORD_AMNT      = 2047,
  parameter int RAM_WID        = 32,
  parameter int RAM_WORD_WID   = 16,
  parameter int RAM_WORD_INCR  = 2,
  parameter int FIFO_DEPTH_WID = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    refresh_start,
  input  logic [RAM_WID-1:0]      start_addr,
  output logic                    refresh_finished,
  output logic [RAM_WID-1:0]      ram_dma_addr,
  input  logic [RAM_WORD_WID-1:0] ram_word,
  output logic                    ram_read,
  input  logic                    ram_valid,
  output logic [WORD_WID-1:0]     word,
  input  logic                    word_next,
  output logic                    word_ok,
  output logic                    word_last,
  input  logic                    word_rst
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_WID;
  localparam int SAMPLES = WORD_AMNT + 1;
  localparam int HI_WID  = WORD_WID - RAM_WORD_WID;
  localparam logic [RAM_WID-1:0]       WORD_STEP   = RAM_WID'(RAM_WORD_INCR);
  localparam logic [RAM_WID-1:0]       SAMPLE_STEP = RAM_WID'(2 * RAM_WORD_INCR);
  localparam logic [WORD_AMNT_WID-1:0] LAST_IDX    = WORD_AMNT_WID'(WORD_AMNT);

  typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, FULL} state_t;

  state_t                    state_reg;
  logic [RAM_WID-1:0]        base_reg;
  logic [RAM_WID-1:0]        lo_addr_reg;
  logic [WORD_AMNT_WID-1:0]  fetch_idx_reg;
  logic [RAM_WORD_WID-1:0]   lo_reg;
  logic                      ram_read_reg;
  logic [RAM_WID-1:0]        ram_dma_addr_reg;
  logic                      discard_reg;
  logic                      refresh_start_d_reg;
  logic                      refresh_finished_reg;

  logic [WORD_WID:0]         fifo_mem [DEPTH];
  logic [FIFO_DEPTH_WID-1:0] wr_ptr_reg;
  logic [FIFO_DEPTH_WID-1:0] rd_ptr_reg;
  logic [FIFO_DEPTH_WID:0]   count_reg;
  logic [FIFO_DEPTH_WID:0]   count_next;
  logic [WORD_WID-1:0]       word_reg;
  logic                      word_last_reg;
  logic                      word_ok_reg;

  logic              refresh_rise;
  logic              flush;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [WORD_WID:0] push_data;

  assign refresh_rise = refresh_start && !refresh_start_d_reg;
  assign flush        = refresh_rise || word_rst;
  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (int'(count_reg) == DEPTH);
  // Data for a read that straddled a flush never reaches the FIFO.
  assign push = (state_reg == REQ_HI) && ram_read_reg && ram_valid && !discard_reg && !flush;
  assign pop  = word_next && !word_ok_reg && !fifo_empty && !flush;
  assign push_data = {fetch_idx_reg == LAST_IDX, ram_word[HI_WID-1:0], lo_reg};

  if (HI_WID < RAM_WORD_WID) begin : g_unused_hi
    logic unused_hi_bits;
    assign unused_hi_bits = &{1'b0, ram_word[RAM_WORD_WID-1:HI_WID]};
  end

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      base_reg         <= '0;
      lo_addr_reg      <= '0;
      fetch_idx_reg    <= '0;
      lo_reg           <= '0;
      ram_read_reg     <= 1'b0;
      ram_dma_addr_reg <= '0;
      discard_reg      <= 1'b0;
    end else begin
      if (refresh_rise)
        base_reg <= start_addr;
      if (flush) begin
        fetch_idx_reg <= '0;
        lo_addr_reg   <= refresh_rise ? start_addr : base_reg;
      end else if (push) begin
        if (fetch_idx_reg == LAST_IDX) begin
          fetch_idx_reg <= '0;
          lo_addr_reg   <= base_reg;
        end else begin
          fetch_idx_reg <= fetch_idx_reg + 1'b1;
          lo_addr_reg   <= lo_addr_reg + SAMPLE_STEP;
        end
      end
      unique case (state_reg)
        IDLE: if (refresh_rise) state_reg <= REQ_LO;
        REQ_LO, REQ_HI: begin
          if (ram_read_reg) begin
            // An outstanding read cannot be aborted; it completes and may be discarded.
            if (ram_valid) begin
              ram_read_reg <= 1'b0;
              discard_reg  <= 1'b0;
              if (discard_reg || flush) begin
                state_reg <= REQ_LO;
              end else if (state_reg == REQ_LO) begin
                lo_reg    <= ram_word;
                state_reg <= REQ_HI;
              end else begin
                state_reg <= (int'(count_next) == DEPTH) ? FULL : REQ_LO;
              end
            end else if (flush) begin
              discard_reg <= 1'b1;
            end
          end else if (flush) begin
            state_reg <= REQ_LO;
          end else begin
            ram_read_reg     <= 1'b1;
            ram_dma_addr_reg <= (state_reg == REQ_LO) ? lo_addr_reg : lo_addr_reg + WORD_STEP;
          end
        end
        FULL: if (flush || !fifo_full) state_reg <= REQ_LO;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A refresh held high through reset must not count as a new rising edge.
  always_ff @(posedge clk) begin
    refresh_start_d_reg <= refresh_start;
    if (rst || !refresh_start || refresh_rise)
      refresh_finished_reg <= 1'b0;
    else if (fifo_full || int'(count_reg) == SAMPLES)
      refresh_finished_reg <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      word_reg      <= '0;
      word_last_reg <= 1'b0;
      word_ok_reg   <= 1'b0;
    end else begin
      count_reg   <= count_next;
      word_ok_reg <= pop;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop) begin
          rd_ptr_reg                <= rd_ptr_reg + 1'b1;
          {word_last_reg, word_reg} <= fifo_mem[rd_ptr_reg];
        end
      end
    end
  end

  assign refresh_finished = refresh_finished_reg;
  assign ram_dma_addr     = ram_dma_addr_reg;
  assign ram_read         = ram_read_reg;
  assign word             = word_reg;
  assign word_ok          = word_ok_reg;
  assign word_last        = word_last_reg;

endmodule

// File: tb/tb_waveform_prefetch.sv
// Scoreboard bench for waveform_prefetch with a short waveform (WORD_AMNT=4) so that
// priming, index wrap, backpressure, rewind, re-refresh and reset share one run.
module tb_waveform_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        refresh_start;
  logic [31:0] start_addr;
  logic        refresh_finished;
  logic [31:0] ram_dma_addr;
  logic [15:0] ram_word;
  logic        ram_read;
  logic        ram_valid;
  logic [19:0] word;
  logic        word_next;
  logic        word_ok;
  logic        word_last;
  logic        word_rst;

  int tests = 0;
  int failed = 0;
  int lat = 3;
  int stream_idx = 0;
  logic [3:0]  cur_hi = 4'hA;
  logic [15:0] cur_lo = 16'h0000;
  logic [31:0] addr_log[$];
  logic [20:0] exp_q[$];

  waveform_prefetch #(.WORD_AMNT(4)) dut (
    .clk(clk), .rst(rst), .refresh_start(refresh_start), .start_addr(start_addr),
    .refresh_finished(refresh_finished), .ram_dma_addr(ram_dma_addr), .ram_word(ram_word),
    .ram_read(ram_read), .ram_valid(ram_valid), .word(word), .word_next(word_next),
    .word_ok(word_ok), .word_last(word_last), .word_rst(word_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Low word of sample i at base+4i is a ramp, high word is a region tag.
  function automatic logic [15:0] ram_data(input logic [31:0] a);
    logic [31:0] off;
    if (a >= 32'h2000) begin
      off = a - 32'h2000;
      ram_data = off[1] ? 16'h000B : 16'h0100 + off[17:2];
    end else begin
      off = a - 32'h1000;
      ram_data = off[1] ? 16'h000A : off[17:2];
    end
  endfunction

  // RAM model: answers each new request after lat cycles, logs every address.
  initial begin
    logic        busy;
    int          cnt;
    logic [31:0] a;
    busy = 1'b0; cnt = 0; a = '0;
    ram_valid = 1'b0; ram_word = '0;
    forever begin
      @(posedge clk); #1;
      ram_valid = 1'b0;
      if (busy) begin
        if (cnt == 0) begin
          ram_valid = 1'b1;
          ram_word  = ram_data(a);
          busy      = 1'b0;
        end else begin
          cnt--;
        end
      end else if (ram_read) begin
        a = ram_dma_addr;
        addr_log.push_back(a);
        busy = 1'b1;
        cnt  = lat - 1;
      end
    end
  end

  // Monitor: every word_ok strobe is matched against the head of the expected queue.
  initial begin
    logic        prev_ok;
    logic [20:0] e;
    prev_ok = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (word_ok) begin
        check("ok_width", 32'(prev_ok), 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_word: got 0x%0h expected none", {word_last, word});
        end else begin
          e = exp_q.pop_front();
          $display("[TB] word_ok word=0x%05h last=%0d", word, word_last);
          check("word", 32'({word_last, word}), 32'(e));
        end
      end
      prev_ok = word_ok;
    end
  end

  task automatic consume(input int n);
    int         idx;
    logic       seen;
    logic [20:0] e;
    for (int k = 0; k < n; k++) begin
      idx = stream_idx % 5;
      e = {idx == 4, cur_hi, cur_lo + 16'(idx)};
      exp_q.push_back(e);
      stream_idx++;
      word_next = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(posedge clk); #1;
        if (word_ok) begin
          seen = 1'b1;
          break;
        end
      end
      word_next = 1'b0;
      if (!seen) begin
        tests++;
        failed++;
        $display("FAIL consume_timeout: got no word_ok expected 0x%0h", e);
        void'(exp_q.pop_back());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic prev;
    int   n;
    int   highs;
    int   oks;
    rst = 1'b1; refresh_start = 1'b0; start_addr = '0;
    word_next = 1'b0; word_rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_ram_read", 32'(ram_read), 32'd0);
    check("rst_addr", ram_dma_addr, 32'd0);
    check("rst_word_ok", 32'(word_ok), 32'd0);
    check("rst_finished", 32'(refresh_finished), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("idle_no_reads", 32'(addr_log.size()), 32'd0);

    // Prime from 0x1000 with latency 3.
    start_addr = 32'h1000; refresh_start = 1'b1;
    @(posedge clk); #1;
    check("prime_finished_low", 32'(refresh_finished), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (refresh_finished) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("prime_finished", 32'(seen), 32'd1);
    n = addr_log.size();
    check("prime_reads_at_finished", 32'(n == 10 || n == 11), 32'd1);

    // Backpressure: FIFO fills to 8 and fetching stops.
    repeat (150) @(posedge clk); #1;
    highs = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (ram_read) highs++;
    end
    check("full_no_read", 32'(highs), 32'd0);
    check("full_reads", 32'(addr_log.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      check("prime_addr", addr_log[k], 32'h1000 + 32'(4 * ((k / 2) % 5) + 2 * (k % 2)));
    check("finished_held", 32'(refresh_finished), 32'd1);

    consume(1);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (ram_read) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("resume_after_pop", 32'(seen), 32'd1);
    consume(11);

    // Rewind while a slow high-word read is outstanding.
    lat = 10;
    consume(2);
    seen = 1'b0; prev = ram_read;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (ram_read && !prev && ram_dma_addr[1]) begin seen = 1'b1; break; end
      prev = ram_read;
    end
    check("hi_req_seen", 32'(seen), 32'd1);
    word_rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rewind_read_held", 32'(ram_read), 32'd1);
    word_rst = 1'b0;
    stream_idx = 0;
    for (int c = 0; c < 100 && ram_read; c++) begin
      @(posedge clk); #1;
    end
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (ram_read) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rewind_req", 32'(seen), 32'd1);
    check("rewind_addr", ram_dma_addr, 32'h1000);
    consume(1);

    // Re-refresh from 0x2000 with the FIFO partly filled.
    lat = 3;
    repeat (60) @(posedge clk); #1;
    refresh_start = 1'b0;
    @(posedge clk); #1;
    check("finished_drop", 32'(refresh_finished), 32'd0);
    start_addr = 32'h2000; refresh_start = 1'b1;
    @(posedge clk); #1;
    check("rerefresh_finished_low", 32'(refresh_finished), 32'd0);
    stream_idx = 0; cur_hi = 4'hB; cur_lo = 16'h0100;
    consume(5);
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (refresh_finished) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rerefresh_finished", 32'(seen), 32'd1);
    consume(3);

    // Reset with a response still pending.
    lat = 5;
    seen = 1'b0; prev = ram_read;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (ram_read && !prev) begin seen = 1'b1; break; end
      prev = ram_read;
    end
    check("pre_reset_req", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; refresh_start = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ram_read", 32'(ram_read), 32'd0);
    check("mid_rst_addr", ram_dma_addr, 32'd0);
    check("mid_rst_word", 32'(word), 32'd0);
    check("mid_rst_word_last", 32'(word_last), 32'd0);
    check("mid_rst_word_ok", 32'(word_ok), 32'd0);
    check("mid_rst_finished", 32'(refresh_finished), 32'd0);
    rst = 1'b0;
    highs = 0; oks = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ram_read) highs++;
      if (word_ok) oks++;
    end
    check("post_rst_no_read", 32'(highs), 32'd0);
    check("post_rst_no_ok", 32'(oks), 32'd0);
    start_addr = 32'h1000; refresh_start = 1'b1;
    stream_idx = 0; cur_hi = 4'hA; cur_lo = 16'h0000;
    @(posedge clk); #1;
    consume(1);

    @(posedge clk); #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/waveform_prefetch.md
# waveform_prefetch

Streaming sample fetcher that sits directly upstream of the waveform DAC driver. It reads waveform samples from system RAM over the DMA read port, packs two RAM words into one DAC sample, and buffers the samples in a small FIFO. It serves them to the consumer over the word_next/word_ok/word_last handshake. The address wraps so the waveform repeats indefinitely, and fetching stays ahead of the consumer so DAC updates are never stalled by RAM latency.

## Interface

Parameters:
- WORD_WID, 20: DAC sample width; must satisfy RAM_WORD_WID < WORD_WID <= 2*RAM_WORD_WID.
- WORD_AMNT_WID, 11: width of the sample index.
- WORD_AMNT, 2047: index of the last sample in the waveform; sample count is WORD_AMNT+1.
- RAM_WID, 32: RAM address width.
- RAM_WORD_WID, 16: width of one RAM read.
- RAM_WORD_INCR, 2: address step between consecutive RAM words.
- FIFO_DEPTH_WID, 3: log2 of FIFO depth (default depth 8).

Ports:
- clk  in  1  system clock; everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- refresh_start  in  1  level; start or restart streaming from start_addr.
- start_addr  in  RAM_WID  base address of sample 0; sampled on refresh_start rising edge.
- refresh_finished  out  1  FIFO primed after refresh; held while refresh_start is high.
- ram_dma_addr  out  RAM_WID  RAM read address.
- ram_word  in  RAM_WORD_WID  RAM read data, valid with ram_valid.
- ram_read  out  1  RAM read request.
- ram_valid  in  1  read-data strobe.
- word  out  WORD_WID  sample presented to the consumer.
- word_next  in  1  level; consumer requests a sample.
- word_ok  out  1  one-cycle strobe; word and word_last are valid.
- word_last  out  1  presented sample has index WORD_AMNT.
- word_rst  in  1  level; rewind the stream to sample 0.

## Operation

- Sample i is stored as a low RAM word at base + 2*i*RAM_WORD_INCR and a high RAM word at base + (2*i+1)*RAM_WORD_INCR.
- Packing: word = {high[WORD_WID-RAM_WORD_WID-1:0], low}; the remaining high bits are ignored.
- Address arithmetic is RAM_WID modulo; overflow wraps silently.
- The FIFO stores {last_flag, sample}. last_flag is set for sample index WORD_AMNT.
- After fetching index WORD_AMNT, the fetch index wraps to 0 and the address returns to the base.
- Fetch FSM states: IDLE, REQ_LO, REQ_HI, FULL.
  - IDLE: the base is not yet valid; nothing is fetched.
  - REQ_LO: ram_read high, ram_dma_addr set to the low-word address. Both are held until ram_valid, then the low word is latched and the FSM goes to REQ_HI.
  - REQ_HI: same handshake for the high word. On ram_valid the sample is pushed, the index advances, and the FSM goes to FULL if the FIFO is now full, otherwise to REQ_LO.
  - FULL: wait until the FIFO is not full, then go to REQ_LO.
- RAM handshake:
  - ram_read is low for at least one cycle after every ram_valid.
  - ram_dma_addr only changes while ram_read is low.
  - A ram_valid seen while ram_read is low is ignored.
- Refresh: on the refresh_start rising edge:
  - latch start_addr as the base, flush the FIFO, set the fetch index to 0, and mark the base valid;
  - clear refresh_finished;
  - refresh_finished goes high once the FIFO is full or holds WORD_AMNT+1 entries, and stays high until refresh_start falls.
- Rewind: while word_rst is high, the FIFO is flushed every cycle, the fetch index is held at 0, and pops are suppressed. Fetching resumes from sample 0 in the cycle after word_rst falls.
- Flush during an outstanding read (refresh or word_rst while in REQ_LO or REQ_HI):
  - the read cannot be aborted;
  - ram_read stays high until ram_valid, that data is discarded, and the FSM then goes to REQ_LO at the new start point.
- Consumer pop condition: word_next && !word_ok && FIFO not empty && !word_rst.
  - On a pop, the next cycle has word_ok=1 with the head entry on word and word_last.
  - word and word_last then hold until the next pop.
  - The !word_ok term guarantees one pop per request, for a consumer that drops word_next on the edge where it sees word_ok.
- Simultaneous push and pop in one cycle are both honoured; the occupancy count is unchanged.
- rst dominates all other inputs:
  - FSM to IDLE, base invalid, FIFO empty;
  - all outputs 0 (ram_dma_addr 0, ram_read 0, word 0, word_ok 0, word_last 0, refresh_finished 0);
  - any in-flight RAM response after rst is ignored.

## Timing

- Pop latency: word_next sampled high with the FIFO non-empty at edge N gives word_ok high for the cycle after edge N. When the FIFO is empty, word_ok follows the first push by one cycle.
- Fetch throughput: at most one sample per 2*(RAM latency+1)+2 cycles.
- refresh_finished with zero-wait RAM: 2^FIFO_DEPTH_WID pushes after the refresh edge, each push at least 4 cycles apart.
- word_rst falling at edge N: first ram_read for sample 0 is high after edge N+1.

## Test plan

- Prime: RAM data at 0x1000 is a ramp with low=i, high=0xA; refresh_start with start_addr=0x1000; RAM latency 3. Expect reads at addresses 0x1000, 0x1002, 0x1004, ... and refresh_finished after 8 samples. Eight word_next pulses then yield word=0xA0000+i for i=0..7, each word_ok exactly one cycle wide.
- Wrap: WORD_AMNT=4, depth 8; consume 12 samples. Expect indices 0,1,2,3,4,0,1,...; word_last=1 only on index 4; address returns to the base after the sample-4 high word.
- Backpressure: no word_next for 200 cycles. Expect ram_read to stay low once the FIFO is full (FULL state), and fetching to resume within 2 cycles of the first pop.
- Mid-read flush: assert word_rst while REQ_HI is waiting with latency 10. Expect ram_read held until ram_valid, data discarded, and the next read at base+0 after word_rst falls; the first word_ok returns sample 0.
- Re-refresh: refresh_start falls, then rises with start_addr=0x2000 while the FIFO is half full. Expect the old data flushed, the first word equal to the sample at 0x2000, and refresh_finished 0 until re-primed.
- Reset: assert rst mid-fetch with a pending ram_valid. Expect all outputs 0 next cycle, the late ram_valid ignored, and no reads until the next refresh_start.
